wb_port_arbiter: RTL

Arbitrates the single register-file write port between the in-order writeback path and a long-latency unit (MUL/DIV) result stream. Long-unit results are buffered and slotted into free write cycles, with a bounded-starvation stall of the pipeline. The block also keeps a scoreboard of destination registers with outstanding long-latency results for the issue-side hazard check. It sits between the WB stage, the long-latency unit and the register file.

---
 rtl/wb_port_arbiter_if.sv | 64 ++++++
 rtl/wb_port_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter_if.sv
// Signal bundle between the WB stage, the long-latency unit, the issue-side
// hazard check and the register-file write port of wb_port_arbiter.
//
// Handshake: the long-unit transfer is strict valid/ready. A result moves
// into the arbiter at a rising edge where lu_valid and lu_ready are both 1.
// The producer keeps lu_valid, lu_rd and lu_wdata stable until that edge.
// lu_ready does not depend on lu_valid.
interface wb_port_arbiter_if #(
  parameter int XLEN = 32
);
  // Pipeline writeback request
  logic            wb_we;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_wdata;

  // Long-latency unit result stream
  logic            lu_valid;
  logic            lu_ready;
  logic [4:0]      lu_rd;
  logic [XLEN-1:0] lu_wdata;

  // Issue-side scoreboard access
  logic            iss_valid;
  logic [4:0]      iss_rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic            rs1_busy;
  logic            rs2_busy;

  // Pipeline hold request
  logic            pipe_stall;

  // Register-file write port
  logic            rf_we;
  logic [4:0]      rf_rd;
  logic [XLEN-1:0] rf_wdata;

  // Arbiter FSM state, for checkers and waveform debug
  logic [1:0]      dbg_state;

  // Arbiter side
  modport slave (
    input  wb_we, wb_rd, wb_wdata,
    input  lu_valid, lu_rd, lu_wdata,
    output lu_ready,
    input  iss_valid, iss_rd, rs1, rs2,
    output rs1_busy, rs2_busy,
    output pipe_stall,
    output rf_we, rf_rd, rf_wdata,
    output dbg_state
  );

  // Environment side: pipeline, long unit, issue logic and register file
  modport master (
    output wb_we, wb_rd, wb_wdata,
    output lu_valid, lu_rd, lu_wdata,
    input  lu_ready,
    output iss_valid, iss_rd, rs1, rs2,
    input  rs1_busy, rs2_busy,
    input  pipe_stall,
    input  rf_we, rf_rd, rf_wdata,
    input  dbg_state
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter.
// The in-order WB path normally owns the write port. A long-latency result
// is parked in a one-entry hold register and written in the first cycle the
// pipeline leaves the port free. After STARVE_LIMIT denied cycles the
// pipeline is stalled for one cycle so that the held result can be written.
// A scoreboard tracks destinations of issued long-latency ops until their
// result reaches the register file.
module wb_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int XLEN         = 32
) (
  input  logic           clk,
  input  logic           rst,
  wb_port_arbiter_if.slave bus
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HELD  = 2'd1,
    ST_FORCE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   wait_cnt;
  logic [CW-1:0]   wait_nxt;
  logic [CW-1:0]   wait_inc;
  logic [4:0]      h_rd;
  logic [XLEN-1:0] h_data;
  logic [31:0]     pending;
  logic [31:0]     pending_nxt;
  logic [31:0]     set_mask;
  logic [31:0]     clr_mask;

  logic            pipe_req;
  logic            capture;
  logic            hold_wr;

  // Pipeline needs the port only for a real register write; x0 writes are free.
  assign pipe_req = bus.wb_we && (bus.wb_rd != 5'd0);
  assign wait_inc = wait_cnt + CW'(1);
  assign bus.dbg_state = state;

  // Next-state and port-mux decode; everything is forced idle while in reset.
  always_comb begin
    state_nxt      = state;
    wait_nxt       = wait_cnt;
    capture        = 1'b0;
    hold_wr        = 1'b0;
    bus.lu_ready   = 1'b0;
    bus.pipe_stall = 1'b0;
    bus.rf_we      = 1'b0;
    bus.rf_rd      = 5'd0;
    bus.rf_wdata   = '0;
    if (!rst) begin
      unique case (state)
        ST_EMPTY: begin
          bus.lu_ready = 1'b1;
          if (pipe_req) begin
            bus.rf_we    = 1'b1;
            bus.rf_rd    = bus.wb_rd;
            bus.rf_wdata = bus.wb_wdata;
          end
          if (bus.lu_valid) begin
            capture   = 1'b1;
            wait_nxt  = '0;
            state_nxt = ST_HELD;
          end
        end
        ST_HELD: begin
          if (!pipe_req) begin
            hold_wr   = 1'b1;
            state_nxt = ST_EMPTY;
          end else begin
            bus.rf_we    = 1'b1;
            bus.rf_rd    = bus.wb_rd;
            bus.rf_wdata = bus.wb_wdata;
            wait_nxt     = wait_inc;
            if (wait_inc == CW'(STARVE_LIMIT)) begin
              state_nxt = ST_FORCE;
            end
          end
        end
        ST_FORCE: begin
          // The pipeline write is dropped this cycle and re-presented next.
          bus.pipe_stall = 1'b1;
          hold_wr        = 1'b1;
          state_nxt      = ST_EMPTY;
        end
        default: begin
          state_nxt = ST_EMPTY;
        end
      endcase
      // A held result for x0 is retired without touching the register file.
      if (hold_wr) begin
        bus.rf_we    = (h_rd != 5'd0);
        bus.rf_rd    = h_rd;
        bus.rf_wdata = h_data;
      end
    end
  end

  // FSM state, starvation counter and hold register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_EMPTY;
      wait_cnt <= '0;
      h_rd     <= 5'd0;
      h_data   <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (capture) begin
        h_rd   <= bus.lu_rd;
        h_data <= bus.lu_wdata;
      end
    end
  end

  // Scoreboard masks: a new issue to the same rd overrides the retiring clear.
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (bus.iss_valid && (bus.iss_rd != 5'd0)) begin
      set_mask[bus.iss_rd] = 1'b1;
    end
    if (hold_wr) begin
      clr_mask[h_rd] = 1'b1;
    end
    pending_nxt    = (pending & ~clr_mask) | set_mask;
    pending_nxt[0] = 1'b0;
  end

  // Scoreboard register; x0 never becomes pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt;
    end
  end

  // Hazard lookups for the two issuing sources.
  always_comb begin
    bus.rs1_busy = 1'b0;
    bus.rs2_busy = 1'b0;
    if (!rst) begin
      bus.rs1_busy = (bus.rs1 != 5'd0) && pending[bus.rs1];
      bus.rs2_busy = (bus.rs2 != 5'd0) && pending[bus.rs2];
    end
  end

endmodule
